// File: rtl/spin_tick_controller.sv
// spin_tick_controller
// Debounces a raw Start push-button into toggle presses, runs a small
// IDLE/RUN/HOLD controller and divides Clk down into one-cycle Step pulses
// that advance a 0..5 disk Phase for the spin animation.
`timescale 1ns/1ps
module spin_tick_controller #(
    parameter int DB_CYCLES = 4,
    parameter int STEP_DIV  = 5
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       Start,
    input  logic       Hold,
    output logic       Run,
    output logic       Step,
    output logic [2:0] Phase
);

    localparam logic [7:0]  DB_LAST   = 8'(DB_CYCLES - 1);
    localparam logic [15:0] DIV_LAST  = 16'(STEP_DIV - 1);
    localparam logic [2:0]  PHASE_MAX = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic        sync1_r;
    logic        sync2_r;
    logic        deb_r;
    logic        deb_d_r;
    logic        press_r;
    logic [7:0]  db_cnt_r;
    state_t      state_r;
    state_t      state_s;
    logic [15:0] presc_r;
    logic [15:0] presc_s;
    logic [2:0]  phase_r;
    logic [2:0]  phase_s;
    logic        step_s;
    logic        step_r;
    logic        run_r;

    // Two-flop synchronizer for the asynchronous push-button.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= Start;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: accept a new level only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            deb_r    <= 1'b0;
            db_cnt_r <= 8'd0;
        end else if (sync2_r != deb_r) begin
            if (db_cnt_r == DB_LAST) begin
                deb_r    <= sync2_r;
                db_cnt_r <= 8'd0;
            end else begin
                db_cnt_r <= db_cnt_r + 8'd1;
            end
        end else begin
            db_cnt_r <= 8'd0;
        end
    end

    // Registered one-cycle press pulse on the debounced rising edge only.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            deb_d_r <= 1'b0;
            press_r <= 1'b0;
        end else begin
            deb_d_r <= deb_r;
            press_r <= deb_r & ~deb_d_r;
        end
    end

    // Next-state, prescaler and phase logic; a press always outranks Hold.
    always_comb begin
        state_s = state_r;
        presc_s = presc_r;
        phase_s = phase_r;
        step_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                presc_s = 16'd0;
                if (press_r) begin
                    state_s = ST_RUN;
                    phase_s = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (press_r) begin
                    state_s = ST_IDLE;
                    presc_s = 16'd0;
                end else if (Hold) begin
                    // Freeze the prescaler where it is; no step on the way out.
                    state_s = ST_HOLD;
                end else if (presc_r >= DIV_LAST) begin
                    presc_s = 16'd0;
                    step_s  = 1'b1;
                    // Wrap 5 -> 0; any out-of-range value also recovers to 0.
                    if (phase_r >= PHASE_MAX) begin
                        phase_s = 3'd0;
                    end else begin
                        phase_s = phase_r + 3'd1;
                    end
                end else begin
                    presc_s = presc_r + 16'd1;
                end
            end
            ST_HOLD: begin
                if (press_r) begin
                    state_s = ST_IDLE;
                    presc_s = 16'd0;
                end else if (!Hold) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_IDLE;
                presc_s = 16'd0;
                phase_s = 3'd0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r <= ST_IDLE;
            presc_r <= 16'd0;
            phase_r <= 3'd0;
            step_r  <= 1'b0;
            run_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            presc_r <= presc_s;
            phase_r <= phase_s;
            step_r  <= step_s;
            run_r   <= (state_s != ST_IDLE);
        end
    end

    assign Run   = run_r;
    assign Step  = step_r;
    assign Phase = phase_r;

endmodule

// File: tb/tb_spin_tick_controller.sv
// Scoreboard bench for spin_tick_controller with default parameters.
// Edge k is counted from the edge after Start is first driven high
// (k=1 is the first edge that samples Start high).
`timescale 1ns/1ps
module tb_spin_tick_controller;

    logic       Clk = 1'b0;
    logic       nReset;
    logic       Start;
    logic       Hold;
    logic       Run;
    logic       Step;
    logic [2:0] Phase;

    int cyc     = 0;
    int base_k  = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         k;
        logic       run;
        logic       step;
        logic [2:0] phase;
    } exp_t;

    exp_t sb[$];

    spin_tick_controller #(.DB_CYCLES(4), .STEP_DIV(5)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .Start  (Start),
        .Hold   (Hold),
        .Run    (Run),
        .Step   (Step),
        .Phase  (Phase)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge k=%0d)", tag, got, exp, cyc - base_k);
        end
    endtask

    task automatic push(input int k, input bit run, input bit step, input int phase);
        exp_t e;
        e.k     = base_k + k;
        e.run   = run;
        e.step  = step;
        e.phase = 3'(phase);
        sb.push_back(e);
    endtask

    task automatic at_edge(input int k);
        while (cyc < base_k + k) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Compare DUT outputs against queued expectations between clock edges.
    always @(negedge Clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].k <= cyc) begin
            e = sb.pop_front();
            if (e.k < cyc) begin
                check_eq("sb_late", e.k, cyc);
            end else begin
                check_eq("run", int'(Run), int'(e.run));
                check_eq("step", int'(Step), int'(e.step));
                check_eq("phase", int'(Phase), int'(e.phase));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        nReset = 1'b0;
        Start  = 1'b0;
        Hold   = 1'b0;
        #3;
        check_eq("rst_run", int'(Run), 0);
        check_eq("rst_step", int'(Step), 0);
        check_eq("rst_phase", int'(Phase), 0);
        repeat (2) @(posedge Clk);
        #1 nReset = 1'b1;
        @(posedge Clk);
        #1;
        base_k = cyc;

        // Press and hold: Run at k=8, steps every 5 from k=13, 31+ steps.
        Start = 1'b1;
        for (int k = 1; k <= 170; k++)
            push(k, k >= 8, (k >= 13) && ((k - 13) % 5 == 0), (k < 13) ? 0 : (((k - 13) / 5 + 1) % 6));

        // Hold for 12 edges with the prescaler at 2 (last step at k=168).
        at_edge(170);
        Hold = 1'b1;
        for (int k = 171; k <= 185; k++) push(k, 1'b1, 1'b0, 2);

        at_edge(182);
        Hold = 1'b0;
        for (int k = 186; k <= 210; k++) push(k, 1'b1, (k - 186) % 5 == 0, (3 + (k - 186) / 5) % 6);

        // Release, then second press: stop lands on a would-be step edge (k=211).
        at_edge(197);
        Start = 1'b0;
        at_edge(203);
        Start = 1'b1;
        for (int k = 211; k <= 247; k++) push(k, 1'b0, 1'b0, 1);

        // Release, then a 3-cycle glitch that must be ignored.
        at_edge(215);
        Start = 1'b0;
        at_edge(224);
        Start = 1'b1;
        at_edge(227);
        Start = 1'b0;

        // Third press restarts phase at 0.
        at_edge(240);
        Start = 1'b1;
        for (int k = 248; k <= 254; k++) push(k, 1'b1, k == 253, (k >= 253) ? 1 : 0);
        push(255, 1'b0, 1'b0, 0);

        // 3 ns reset pulse between edges during RUN, Start held across release.
        at_edge(255);
        nReset = 1'b0;
        #1;
        check_eq("async_rst_run", int'(Run), 0);
        check_eq("async_rst_step", int'(Step), 0);
        check_eq("async_rst_phase", int'(Phase), 0);
        #2 nReset = 1'b1;
        for (int k = 256; k <= 270; k++) push(k, k >= 263, k == 268, (k >= 268) ? 1 : 0);

        at_edge(272);
        check_eq("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
